// File: rtl/audio_event_sequencer_pkg.sv
// rtl/audio_event_sequencer_pkg.sv - shared types and constants for the audio event sequencer
package audio_pkg;

   localparam int NUM_AUDIO_EVENTS    = 6;
   localparam int DEFAULT_TONE_CYCLES = 5_000_000;
   localparam int DEFAULT_GAP_CYCLES  = 250_000;

   // Index order doubles as priority order: lower index wins.
   typedef enum logic [2:0] {
      EV_KEY_ENTER  = 3'd0,
      EV_KEY_X      = 3'd1,
      EV_KEY_Y      = 3'd2,
      EV_HOLE_COL   = 3'd3,
      EV_BORDER_COL = 3'd4,
      EV_BALL_COL   = 3'd5
   } audio_event_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } seq_state_e;

   function automatic logic [NUM_AUDIO_EVENTS-1:0] ev_onehot(audio_event_e idx);
      logic [NUM_AUDIO_EVENTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/audio_event_sequencer_if.sv
// rtl/audio_event_sequencer_if.sv - event strobes, mute and tone request levels
interface audio_event_sequencer_if;

   logic keyEnterPulse;
   logic keyXPulse;
   logic keyYPulse;
   logic holeColPulse;
   logic borderColPulse;
   logic ballToBallColPulse;
   logic mute;

   logic keyEnterAudioRequest;
   logic keyXAudioRequest;
   logic keyYAudioRequest;
   logic holeColAudioRequest;
   logic borderColAudioRequest;
   logic ballToBallColAudioRequest;
   logic busy;

   modport master (
      output keyEnterPulse, keyXPulse, keyYPulse, holeColPulse, borderColPulse,
             ballToBallColPulse, mute,
      input  keyEnterAudioRequest, keyXAudioRequest, keyYAudioRequest,
             holeColAudioRequest, borderColAudioRequest, ballToBallColAudioRequest, busy
   );

   modport slave (
      input  keyEnterPulse, keyXPulse, keyYPulse, holeColPulse, borderColPulse,
             ballToBallColPulse, mute,
      output keyEnterAudioRequest, keyXAudioRequest, keyYAudioRequest,
             holeColAudioRequest, borderColAudioRequest, ballToBallColAudioRequest, busy
   );

endinterface

// File: rtl/audio_event_sequencer_prio_enc.sv
// rtl/audio_event_sequencer_prio_enc.sv - fixed-priority selector, lowest pending index wins
module audio_req_prio_enc
   import audio_pkg::*;
(
   input  logic [NUM_AUDIO_EVENTS-1:0] i_pending,
   output logic                        o_valid,
   output audio_event_e                o_index
);

   always_comb begin
      o_valid = |i_pending;
      o_index = EV_KEY_ENTER;
      for (int i = NUM_AUDIO_EVENTS - 1; i >= 0; i--) begin
         if (i_pending[i]) begin
            o_index = audio_event_e'(3'(i));
         end
      end
   end

endmodule

// File: rtl/audio_event_sequencer.sv
// rtl/audio_event_sequencer.sv - queues game sound events and plays them one tone at a time
module audio_event_sequencer
   import audio_pkg::*;
#(
   parameter int TONE_CYCLES = DEFAULT_TONE_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   audio_event_sequencer_if.slave  bus
);

   localparam int MAX_CYCLES = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   generate
      if (TONE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
         $error("audio_event_sequencer: TONE_CYCLES and GAP_CYCLES must be >= 1");
      end
   endgenerate

   logic [NUM_AUDIO_EVENTS-1:0] w_pulse;
   logic [NUM_AUDIO_EVENTS-1:0] w_clr;
   logic [NUM_AUDIO_EVENTS-1:0] r_pending;
   logic                        w_valid;
   audio_event_e                w_idx;
   logic                        w_start;

   seq_state_e                  r_state;
   logic [CNT_W-1:0]            r_cnt;
   audio_event_e                r_idx;
   logic [NUM_AUDIO_EVENTS-1:0] r_req;
   logic                        r_busy;

   assign w_pulse = {bus.ballToBallColPulse, bus.borderColPulse, bus.holeColPulse,
                     bus.keyYPulse, bus.keyXPulse, bus.keyEnterPulse};

   audio_req_prio_enc u_prio (
      .i_pending (r_pending),
      .o_valid   (w_valid),
      .o_index   (w_idx)
   );

   // A tone may start from IDLE, or straight out of an expiring GAP.
   assign w_start = w_valid && !bus.mute &&
                    ((r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_cnt == '0)));
   assign w_clr   = w_start ? ev_onehot(w_idx) : '0;

   // Set wins over clear so a re-trigger in the start cycle queues another tone.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else if (bus.mute) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_pulse;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= EV_KEY_ENTER;
         r_req   <= '0;
         r_busy  <= 1'b0;
      end else if (bus.mute) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_req   <= '0;
         r_busy  <= 1'b0;
      end else if (w_start) begin
         r_state <= ST_PLAY;
         r_cnt   <= TONE_LOAD;
         r_idx   <= w_idx;
         r_req   <= ev_onehot(w_idx);
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_req  <= '0;
               r_busy <= 1'b0;
            end
            ST_PLAY: begin
               if (r_cnt == '0) begin
                  r_state <= ST_GAP;
                  r_cnt   <= GAP_LOAD;
                  r_req   <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
                  r_req <= ev_onehot(r_idx);
               end
               r_busy <= 1'b1;
            end
            ST_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt - 1'b1;
                  r_busy <= 1'b1;
               end
               r_req <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_req   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.keyEnterAudioRequest      = r_req[EV_KEY_ENTER];
   assign bus.keyXAudioRequest          = r_req[EV_KEY_X];
   assign bus.keyYAudioRequest          = r_req[EV_KEY_Y];
   assign bus.holeColAudioRequest       = r_req[EV_HOLE_COL];
   assign bus.borderColAudioRequest     = r_req[EV_BORDER_COL];
   assign bus.ballToBallColAudioRequest = r_req[EV_BALL_COL];
   assign bus.busy                      = r_busy;

endmodule

// File: tb/tb_audio_event_sequencer.sv
// tb/tb_audio_event_sequencer.sv - directed cycle-by-cycle bench for audio_event_sequencer
module tb_audio_event_sequencer;
   import audio_pkg::*;

   localparam int TC = 8;
   localparam int GC = 2;
   localparam int N  = 74;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   audio_event_sequencer_if bus ();

   audio_event_sequencer #(.TONE_CYCLES(TC), .GAP_CYCLES(GC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [5:0] pulse_at [N];
   logic       mute_at  [N];
   logic       rst_at   [N];
   logic [5:0] exp_req  [N];
   logic       exp_busy [N];

   function automatic logic [6:0] observed();
      return {bus.busy, bus.ballToBallColAudioRequest, bus.borderColAudioRequest,
              bus.holeColAudioRequest, bus.keyYAudioRequest, bus.keyXAudioRequest,
              bus.keyEnterAudioRequest};
   endfunction

   task automatic drive_pulses(input logic [5:0] p);
      bus.keyEnterPulse      = p[0];
      bus.keyXPulse          = p[1];
      bus.keyYPulse          = p[2];
      bus.holeColPulse       = p[3];
      bus.borderColPulse     = p[4];
      bus.ballToBallColPulse = p[5];
   endtask

   task automatic chk(input string tag, input int c, input logic [6:0] obs, input logic [6:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed busy,req=%b expected=%b", tag, c, obs, expv);
      end
   endtask

   task automatic clear_tables();
      for (int c = 0; c < N; c++) begin
         pulse_at[c] = '0;
         mute_at[c]  = 1'b0;
         rst_at[c]   = 1'b0;
         exp_req[c]  = '0;
         exp_busy[c] = 1'b0;
      end
   endtask

   task automatic set_req(input int lo, input int hi, input logic [5:0] v);
      for (int c = lo; c <= hi; c++) exp_req[c] = exp_req[c] | v;
   endtask

   task automatic set_busy(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) exp_busy[c] = 1'b1;
   endtask

   task automatic run_tables(input string tag);
      drive_pulses('0);
      bus.mute = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({tag, "_reset"}, -1, observed(), 7'b0);
      reset = 1'b0;
      for (int c = 0; c < N; c++) begin
         chk(tag, c, observed(), {exp_busy[c], exp_req[c]});
         drive_pulses(pulse_at[c]);
         bus.mute = mute_at[c];
         reset    = rst_at[c];
         @(posedge clk); #1;
      end
      drive_pulses('0);
      bus.mute = 1'b0;
      reset    = 1'b0;
   endtask

   initial begin
      drive_pulses('0);
      bus.mute = 1'b0;
      reset    = 1'b1;

      // single hole collision
      clear_tables();
      pulse_at[10] = 6'b001000;
      set_req(12, 19, 6'b001000);
      set_busy(12, 21);
      run_tables("single");

      // simultaneous border + keyEnter
      clear_tables();
      pulse_at[10] = 6'b010001;
      set_req(12, 19, 6'b000001);
      set_req(22, 29, 6'b010000);
      set_busy(12, 31);
      run_tables("simul");

      // no pre-emption, priority among queued events
      clear_tables();
      pulse_at[10] = 6'b000010;
      pulse_at[14] = 6'b100000;
      pulse_at[15] = 6'b000001;
      set_req(12, 19, 6'b000010);
      set_req(22, 29, 6'b000001);
      set_req(32, 39, 6'b100000);
      set_busy(12, 41);
      run_tables("nopreempt");

      // repeated keyY strobes collapse to one tone
      clear_tables();
      pulse_at[10] = 6'b000010;
      pulse_at[14] = 6'b000100;
      pulse_at[15] = 6'b000100;
      pulse_at[16] = 6'b000100;
      set_req(12, 19, 6'b000010);
      set_req(22, 29, 6'b000100);
      set_busy(12, 31);
      run_tables("collapse");

      // mute cuts the tone and ignores pulses while high
      clear_tables();
      pulse_at[10] = 6'b001000;
      mute_at[15]  = 1'b1;
      mute_at[16]  = 1'b1;
      pulse_at[16] = 6'b001000;
      pulse_at[20] = 6'b001000;
      set_req(12, 15, 6'b001000);
      set_busy(12, 15);
      set_req(22, 29, 6'b001000);
      set_busy(22, 31);
      run_tables("mute");

      // reset mid-PLAY with a pending event
      clear_tables();
      pulse_at[10] = 6'b000010;
      pulse_at[13] = 6'b000100;
      rst_at[15]   = 1'b1;
      set_req(12, 15, 6'b000010);
      set_busy(12, 15);
      run_tables("midreset");

      // reset beats a pulse and mute in the same cycle
      clear_tables();
      pulse_at[10] = 6'b000001;
      mute_at[10]  = 1'b1;
      rst_at[10]   = 1'b1;
      run_tables("rstprio");

      // mute beats a pulse in the same cycle
      clear_tables();
      pulse_at[10] = 6'b010000;
      mute_at[10]  = 1'b1;
      run_tables("muteprio");

      // all six at once drain in priority order
      clear_tables();
      pulse_at[10] = 6'b111111;
      set_req(12, 19, 6'b000001);
      set_req(22, 29, 6'b000010);
      set_req(32, 39, 6'b000100);
      set_req(42, 49, 6'b001000);
      set_req(52, 59, 6'b010000);
      set_req(62, 69, 6'b100000);
      set_busy(12, 71);
      run_tables("allsix");

      // re-trigger in the start cycle queues a second tone
      clear_tables();
      pulse_at[10] = 6'b000010;
      pulse_at[11] = 6'b000010;
      set_req(12, 19, 6'b000010);
      set_req(22, 29, 6'b000010);
      set_busy(12, 31);
      run_tables("retrigger");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_event_sequencer.md
AUDIO_EVENT_SEQUENCER -- requirements
Module: audio_event_sequencer

Interface
REQ-001 Parameter TONE_CYCLES, default 5_000_000 (200 ms at 25 MHz), request hold length in clocks.
REQ-002 Parameter GAP_CYCLES, default 250_000 (10 ms at 25 MHz), silence between consecutive tones in clocks.
REQ-003 clk  in  1  single system clock (25 MHz); all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 keyEnterPulse, keyXPulse, keyYPulse, holeColPulse, borderColPulse, ballToBallColPulse  in  1 each  one-cycle event strobes from game logic.
REQ-006 mute  in  1  level; high silences and flushes all sound.
REQ-007 keyEnterAudioRequest, keyXAudioRequest, keyYAudioRequest, holeColAudioRequest, borderColAudioRequest, ballToBallColAudioRequest  out  1 each  registered request levels to the tone decoder.
REQ-008 busy  out  1  high while in PLAY or GAP.

Function
REQ-009 A 6-bit pending register SHALL set bit i on the edge sampling pulse i high; bit i is cleared only when its tone starts, on mute, or on reset.
REQ-010 Simultaneous set and clear of the same pending bit SHALL leave it set, so a re-trigger during its own start cycle is not lost.
REQ-011 Priority SHALL be keyEnter > keyX > keyY > holeCol > borderCol > ballToBallCol.
REQ-012 FSM states SHALL be IDLE, PLAY and GAP.
REQ-013 IDLE with any pending bit: on the next edge, go to PLAY, latch the highest-priority index, clear its pending bit, and load the counter with TONE_CYCLES-1.
REQ-014 In PLAY, exactly the one latched request output SHALL be high (one-hot), for exactly TONE_CYCLES consecutive cycles.
REQ-015 PLAY with counter 0: go to GAP, load the counter with GAP_CYCLES-1, all outputs low.
REQ-016 GAP with counter 0: if any bit is pending, go directly to PLAY per REQ-013; otherwise go to IDLE.
REQ-017 Request outputs SHALL be all-zero in IDLE and GAP.
REQ-018 Latency: a pulse sampled at edge k, with the FSM in IDLE, SHALL raise its request after edge k+1, i.e. 2 clocks from the pulse cycle.
REQ-019 A pulse arriving in PLAY or GAP SHALL NOT pre-empt the current tone; it waits pending. Multiple pulses of the same event while pending collapse to one tone.
REQ-020 mute high SHALL, on that edge: clear pending, force the FSM to IDLE, and drive all outputs low. While mute is high, pulses SHALL be ignored.
REQ-021 The counter width SHALL be $clog2(max(TONE_CYCLES, GAP_CYCLES)) bits, is down-counting, and SHALL never wrap below 0.
REQ-022 TONE_CYCLES and GAP_CYCLES SHALL be at least 1; an elaboration-time check rejects 0.
REQ-023 busy SHALL be registered, consistent with the state in the same cycle.

Reset
REQ-024 On reset: state IDLE, pending 6'b0, counter 0, latched index 0, all request outputs 0, busy 0.
REQ-025 Reset asserted mid-PLAY or mid-GAP SHALL take effect on that edge with no residual request.
REQ-026 Reset SHALL take priority over mute and over pulses in the same cycle.

Structure
REQ-027 Shared package audio_pkg SHALL hold: the event index enum (EV_KEY_ENTER=0 .. EV_BALL_COL=5), NUM_AUDIO_EVENTS=6, the state enum, and the default TONE_CYCLES and GAP_CYCLES constants.
REQ-028 The fixed-priority 6-to-1 selector SHALL be a sub-module, audio_req_prio_enc (combinational: pending in; valid and index out).
REQ-029 Downstream, the tone decoder SHALL consume the request outputs unchanged.

Verification (TONE_CYCLES=8, GAP_CYCLES=2)
REQ-030 Single holeColPulse at cycle 10 -> holeColAudioRequest high cycles 12-19, low from 20; busy high 12-21; IDLE at 22.
REQ-031 borderColPulse and keyEnterPulse in the same cycle 10 -> keyEnter high 12-19; borderCol high 22-29; never both high.
REQ-032 keyXPulse at cycle 10; ballToBallColPulse at 14; keyEnterPulse at 15 -> keyX 12-19; keyEnter 22-29; ballToBall 32-39 (no pre-emption, priority order).
REQ-033 Three keyYPulse strobes at cycles 14, 15 and 16 during an active keyX tone -> exactly one keyY tone after the gap.
REQ-034 Pulse at 10; mute high cycles 15-16; pulse at 16 -> request low from 16; no tone pending; next pulse at 20 -> request at 22.
REQ-035 reset high at cycle 15 during PLAY, with a pending event -> all outputs 0 and busy 0 from 16; no tone plays after reset releases.
